// File: rtl/usb_pkg.sv
// Shared definitions for the FT245-style USB FIFO link (usb and usb_tx).
// Write-side FSM states and default strobe timing at 100 MHz.
package usb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HOLD,
        GAP,
        SI_ASSERT
    } tx_state_e;

    localparam int DEF_DEPTH    = 16;
    localparam int DEF_WR_HIGH  = 6;
    localparam int DEF_HOLD_CYC = 2;
    localparam int DEF_GAP_CYC  = 8;
    localparam int DEF_SI_DELAY = 64;
    localparam int DEF_SI_PULSE = 4;

    localparam int CNT_W = 8;

    function automatic logic [CNT_W-1:0] last_of(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/usb_tx_if.sv
// Byte stream handshake into the host-bound USB writer.
// Transfer happens on a clock where tx_valid && tx_ready.
interface usb_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/usb_tx_fifo.sv
// Synchronous byte FIFO buffering status bytes ahead of the FT chip.
// Flags and level are registered; rd_data shows the current head.
module usb_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wr_data,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_nx;
    logic          do_push;
    logic          do_pop;

    // A full FIFO refuses pushes even when a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        level_nx = level;
        if (do_push && !do_pop) begin
            level_nx = level + 1'b1;
        end else if (!do_push && do_pop) begin
            level_nx = level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level_nx;
            full  <= (level_nx == LW'(DEPTH));
            empty <= (level_nx == '0);
        end
    end

endmodule

// File: rtl/usb_tx.sv
// Host-bound writer for the FT245-style USB FIFO: buffers bytes, strobes wr,
// and pulses SI once the link has been idle after a burst.
module usb_tx
    import usb_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int WR_HIGH  = DEF_WR_HIGH,
    parameter int HOLD_CYC = DEF_HOLD_CYC,
    parameter int GAP_CYC  = DEF_GAP_CYC,
    parameter int SI_DELAY = DEF_SI_DELAY,
    parameter int SI_PULSE = DEF_SI_PULSE
) (
    input  logic                   clk,
    input  logic                   rst,
    usb_tx_if.slave                tx,
    input  logic                   txe,
    input  logic                   rx_busy,
    output logic                   tx_busy,
    output logic                   wr,
    output logic [7:0]             d_out,
    output logic                   d_oe,
    output logic                   SI,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int IW = $clog2(SI_DELAY) + 1;

    localparam logic [CNT_W-1:0] WR_LAST   = last_of(WR_HIGH);
    localparam logic [CNT_W-1:0] HOLD_LAST = last_of(HOLD_CYC);
    localparam logic [CNT_W-1:0] GAP_LAST  = last_of(GAP_CYC);
    localparam logic [CNT_W-1:0] SI_LAST   = last_of(SI_PULSE);
    localparam logic [IW-1:0]    IDLE_MAX  = IW'(SI_DELAY - 1);

    tx_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [IW-1:0]    idle_cnt;
    logic             sent_flag;
    logic             txe_m;
    logic             txe_s;

    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       head;
    logic             push;
    logic             pop;
    logic             si_due;
    logic             start;

    assign tx.tx_ready = !fifo_full;
    assign push        = tx.tx_valid && tx.tx_ready;
    assign pop         = (state == SETUP) && (cnt == WR_LAST);

    assign si_due = fifo_empty && sent_flag && (idle_cnt == IDLE_MAX);
    // The receiver wins any tie for the shared d bus.
    assign start  = !fifo_empty && !txe_s && !rx_busy && !si_due;

    usb_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (tx.tx_data),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // txe is asynchronous to clk; resets to "FT chip full".
    always_ff @(posedge clk) begin
        if (rst) begin
            txe_m <= 1'b1;
            txe_s <= 1'b1;
        end else begin
            txe_m <= txe;
            txe_s <= txe_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || push || state != IDLE) begin
            idle_cnt <= '0;
        end else if (fifo_empty && idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wr        <= 1'b0;
            d_oe      <= 1'b0;
            d_out     <= 8'h00;
            SI        <= 1'b1;
            tx_busy   <= 1'b0;
            sent_flag <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        state   <= SETUP;
                        wr      <= 1'b1;
                        d_oe    <= 1'b1;
                        d_out   <= head;
                        tx_busy <= 1'b1;
                    end else if (si_due) begin
                        state <= SI_ASSERT;
                        SI    <= 1'b0;
                    end
                end
                SETUP: begin
                    if (cnt == WR_LAST) begin
                        state     <= HOLD;
                        cnt       <= '0;
                        wr        <= 1'b0;
                        sent_flag <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state   <= GAP;
                        cnt     <= '0;
                        d_oe    <= 1'b0;
                        tx_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SI_ASSERT: begin
                    if (cnt == SI_LAST) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        SI        <= 1'b1;
                        sent_flag <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx.sv
// Directed bench for usb_tx: scoreboard of pushed bytes checked against an
// FT chip model that latches d_out on each falling edge of wr.
module tb_usb_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       txe;
    logic       rx_busy;
    logic       tx_busy;
    logic       wr;
    logic [7:0] d_out;
    logic       d_oe;
    logic       SI;
    logic [4:0] fifo_level;

    usb_tx_if bus();

    usb_tx dut (
        .clk        (clk),
        .rst        (rst),
        .tx         (bus),
        .txe        (txe),
        .rx_busy    (rx_busy),
        .tx_busy    (tx_busy),
        .wr         (wr),
        .d_out      (d_out),
        .d_oe       (d_oe),
        .SI         (SI),
        .fifo_level (fifo_level)
    );

    int         vectors = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] sb[$];
    int         rise_q[$];
    int         si_pulses = 0;
    int         si_fall = -1;
    int         wr_len = 0;
    int         si_len = 0;
    logic       prev_wr = 1'b0;
    logic       prev_si = 1'b1;

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        bus.tx_valid = 1'b1;
        bus.tx_data  = b;
        if (bus.tx_ready === 1'b1) sb.push_back(b);
        step(1);
        bus.tx_valid = 1'b0;
    endtask

    // FT chip model: latch on wr fall, track strobe and SI widths.
    always @(negedge clk) begin
        if (!prev_wr && wr) rise_q.push_back(cyc);
        if (wr) wr_len++;
        if (prev_wr && !wr) begin
            if (!rst) begin
                chk("wr_width", wr_len, 6);
                chk("d_oe_at_latch", d_oe, 1);
                chk("write_expected", sb.size() > 0, 1);
                if (sb.size() > 0) chk("ft_data", d_out, sb.pop_front());
            end
            wr_len = 0;
        end
        if (!SI) si_len++;
        if (prev_si && !SI) begin
            si_fall = cyc;
            si_pulses++;
        end
        if (!prev_si && SI) begin
            chk("si_width", si_len, 4);
            si_len = 0;
        end
        if (rst) begin
            wr_len = 0;
            si_len = 0;
        end
        prev_wr = wr;
        prev_si = SI;
    end

    initial begin
        int c0;
        int cq;
        int ct;
        int cu;
        int n0;
        int nr;
        rst          = 1'b1;
        txe          = 1'b0;
        rx_busy      = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        step(3);
        chk("rst_wr", wr, 0);
        chk("rst_d_oe", d_oe, 0);
        chk("rst_d_out", d_out, 0);
        chk("rst_si", SI, 1);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_tx_ready", bus.tx_ready, 1);
        chk("rst_level", fifo_level, 0);
        rst = 1'b0;
        step(4);

        // single byte write and the SI pulse that follows it
        c0 = cyc;
        push(8'hA5);
        chk("a5_level", fifo_level, 1);
        chk("a5_wr_low", wr, 0);
        step(1);
        chk("a5_wr_rise", wr, 1);
        chk("a5_d_out", d_out, 8'hA5);
        chk("a5_d_oe", d_oe, 1);
        chk("a5_busy", tx_busy, 1);
        step(5);
        chk("a5_wr_last", wr, 1);
        step(1);
        chk("a5_wr_fall", wr, 0);
        chk("a5_hold_oe", d_oe, 1);
        chk("a5_hold_data", d_out, 8'hA5);
        chk("a5_level_0", fifo_level, 0);
        step(1);
        chk("a5_hold_oe2", d_oe, 1);
        step(1);
        chk("a5_gap_oe", d_oe, 0);
        chk("a5_gap_busy", tx_busy, 0);
        step(71);
        chk("si_before", SI, 1);
        step(1);
        chk("si_low_first", SI, 0);
        step(3);
        chk("si_low_last", SI, 0);
        step(1);
        chk("si_after", SI, 1);
        chk("si_delay", si_fall, c0 + 82);

        // second push at idle cycle 40 restarts the SI count
        n0 = si_pulses;
        push(8'h5A);
        step(57);
        cq = cyc;
        push(8'hC3);
        step(89);
        chk("restart_pulses", si_pulses, n0 + 1);
        chk("restart_delay", si_fall, cq + 82);
        chk("restart_sb", sb.size(), 0);

        // fill while the FT chip is full, then drain
        txe = 1'b1;
        step(3);
        rise_q.delete();
        for (int i = 1; i <= 16; i++) push(8'(i));
        chk("full_ready", bus.tx_ready, 0);
        chk("full_level", fifo_level, 16);
        push(8'h11);
        chk("ovf_level", fifo_level, 16);
        chk("ovf_sb", sb.size(), 16);
        step(10);
        chk("txe_blocks", rise_q.size(), 0);
        txe = 1'b0;
        ct = cyc;
        step(16 * 17 + 5);
        chk("burst_count", rise_q.size(), 16);
        chk("burst_first", rise_q.size() > 0 ? rise_q[0] : 0, ct + 3);
        for (int i = 1; i < rise_q.size(); i++)
            chk("burst_spacing", rise_q[i] - rise_q[i-1], 17);
        chk("burst_sb", sb.size(), 0);
        step(70);
        chk("burst_si", si_fall,
            (rise_q.size() > 0 ? rise_q[$] : 0) + 80);

        // receiver owns the bus when the start condition appears
        rx_busy = 1'b1;
        nr = rise_q.size();
        push(8'h96);
        step(10);
        chk("rx_no_wr", rise_q.size(), nr);
        chk("rx_wr_low", wr, 0);
        chk("rx_busy_low", tx_busy, 0);
        rx_busy = 1'b0;
        cu = cyc;
        step(1);
        chk("rx_wr_rise", wr, 1);
        chk("rx_rise_cyc", rise_q.size() > 0 ? rise_q[$] : 0, cu + 1);
        step(20);
        chk("rx_sb", sb.size(), 0);

        // reset during SETUP drops the byte and cancels the SI
        push(8'h3C);
        step(2);
        chk("mid_wr_high", wr, 1);
        n0 = si_pulses;
        nr = rise_q.size();
        rst = 1'b1;
        step(1);
        chk("mid_rst_wr", wr, 0);
        chk("mid_rst_oe", d_oe, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_ready", bus.tx_ready, 1);
        chk("mid_rst_busy", tx_busy, 0);
        rst = 1'b0;
        sb.delete();
        step(150);
        chk("post_rst_no_si", si_pulses, n0);
        chk("post_rst_no_wr", rise_q.size(), nr);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
